// File: rtl/mdio_phy_mgr.sv
// MDIO management sequencer: PHY soft-reset sweep and periodic link/speed/duplex polling
// for NUM_PHY PHYs on one MDIO controller. Optional NACK counters under MDIO_ERR_CNT_EN.
module mdio_phy_mgr #(
    parameter int          NUM_PHY       = 2,
    parameter logic [4:0]  PHY_ADDR_BASE = 5'd1,
    parameter logic [23:0] POLL_PERIOD   = 24'd100_000,
    parameter logic [15:0] RST_WORD      = 16'hA140,
    parameter logic [4:0]  STAT_REG      = 5'd17,
    parameter logic [7:0]  RST_MAX_POLLS = 8'd16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   soft_rst_trig,
    input  logic                   op_done,
    input  logic                   op_rd_ack,
    input  logic [15:0]            op_rd_data,
    output logic                   op_exec,
    output logic                   op_rh_wl,
    output logic [4:0]             op_phy_addr,
    output logic [4:0]             op_addr,
    output logic [15:0]            op_wr_data,
    output logic [NUM_PHY-1:0]     link_up,
    output logic [2*NUM_PHY-1:0]   speed,
    output logic [NUM_PHY-1:0]     full_duplex,
    output logic [NUM_PHY-1:0]     rst_fail,
    output logic                   busy,
    output logic [1:0]             led,
    output logic [8*NUM_PHY-1:0]   err_cnt
);

    typedef enum logic [3:0] {
        S_IDLE, S_RST_WR, S_RST_WR_W, S_RST_RD, S_RST_RD_W, S_RST_CHK,
        S_BMSR_RD, S_BMSR_W, S_BMSR_CHK, S_STAT_RD, S_STAT_W, S_STAT_CHK
    } state_t;

    state_t                 r_state, w_state_nx;
    logic [1:0]             r_ch, w_ch_nx;
    logic [7:0]             r_polls, w_polls_nx;
    logic [2:0]             r_sync;
    logic                   r_rst_pend, r_poll_pend;
    logic [23:0]            r_tmr;
    logic [15:0]            r_rd_data;
    logic                   r_rd_ack;
    logic                   r_op_exec, r_op_rh_wl, r_busy;
    logic [4:0]             r_op_phy_addr, r_op_addr;
    logic [15:0]            r_op_wr_data;
    logic [NUM_PHY-1:0]     r_link_up, r_full_duplex, r_rst_fail;
    logic [2*NUM_PHY-1:0]   r_speed;
    logic [1:0]             r_led;

    logic                   w_trig_edge, w_tick, w_last, w_rd_wait;
    logic                   w_issue, w_rd, w_rst_clr, w_poll_clr, w_lnk;
    logic [4:0]             w_reg;
    logic [15:0]            w_wdata;
    logic [1:0]             w_spd;
    logic [NUM_PHY-1:0]     w_sel, w_link_nx, w_dup_nx, w_fail_nx;
    logic [2*NUM_PHY-1:0]   w_smask, w_speed_nx;
    logic                   w_unused;

    assign w_trig_edge = r_sync[1] & ~r_sync[2];
    assign w_tick      = (r_tmr == POLL_PERIOD - 24'd1);
    assign w_last      = (r_ch == 2'(NUM_PHY - 1));
    assign w_rd_wait   = (r_state == S_RST_RD_W) || (r_state == S_BMSR_W) || (r_state == S_STAT_W);
    assign w_unused    = ^{r_rd_data[12:6], r_rd_data[4:3], r_rd_data[1:0]};

    // one-hot select of the current channel, plus its 2-bit-per-PHY speed mask
    always_comb begin
        for (int n = 0; n < NUM_PHY; n++) begin
            w_sel[n]        = (r_ch == 2'(n));
            w_smask[2*n +: 2] = {2{w_sel[n]}};
        end
    end

    // STAT_REG speed decode: encoding 11 is reserved and treated as no link
    always_comb begin
        w_lnk = 1'b1;
        case (r_rd_data[15:14])
            2'b00:   w_spd = 2'b01;
            2'b01:   w_spd = 2'b10;
            2'b10:   w_spd = 2'b11;
            default: begin w_spd = 2'b00; w_lnk = 1'b0; end
        endcase
    end

    // sequencer next state, op request and status updates
    always_comb begin
        w_state_nx = r_state;
        w_ch_nx    = r_ch;
        w_polls_nx = r_polls;
        w_issue    = 1'b0;
        w_rd       = 1'b1;
        w_reg      = 5'd0;
        w_wdata    = 16'h0000;
        w_rst_clr  = 1'b0;
        w_poll_clr = 1'b0;
        w_link_nx  = r_link_up;
        w_speed_nx = r_speed;
        w_dup_nx   = r_full_duplex;
        w_fail_nx  = r_rst_fail;
        case (r_state)
            S_IDLE: begin
                if (r_rst_pend) begin
                    w_rst_clr  = 1'b1;
                    w_fail_nx  = '0;
                    w_ch_nx    = 2'd0;
                    w_state_nx = S_RST_WR;
                end else if (r_poll_pend) begin
                    w_poll_clr = 1'b1;
                    w_ch_nx    = 2'd0;
                    w_state_nx = S_BMSR_RD;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_RST_WR: begin
                w_issue    = 1'b1;
                w_rd       = 1'b0;
                w_wdata    = RST_WORD;
                w_polls_nx = 8'd0;
                w_state_nx = S_RST_WR_W;
            end
            S_RST_WR_W: w_state_nx = op_done ? S_RST_RD : S_RST_WR_W;
            S_RST_RD: begin
                w_issue    = 1'b1;
                w_polls_nx = r_polls + 8'd1;
                w_state_nx = S_RST_RD_W;
            end
            S_RST_RD_W: w_state_nx = op_done ? S_RST_CHK : S_RST_RD_W;
            S_RST_CHK: begin
                if (!r_rd_ack && !r_rd_data[15]) begin
                    w_ch_nx    = w_last ? r_ch : r_ch + 2'd1;
                    w_state_nx = w_last ? S_IDLE : S_RST_WR;
                end else if (r_polls < RST_MAX_POLLS) begin
                    w_state_nx = S_RST_RD;
                end else begin
                    w_fail_nx  = r_rst_fail | w_sel;
                    w_ch_nx    = w_last ? r_ch : r_ch + 2'd1;
                    w_state_nx = w_last ? S_IDLE : S_RST_WR;
                end
            end
            S_BMSR_RD: begin
                w_issue    = 1'b1;
                w_reg      = 5'd1;
                w_state_nx = S_BMSR_W;
            end
            S_BMSR_W: w_state_nx = op_done ? S_BMSR_CHK : S_BMSR_W;
            S_BMSR_CHK: begin
                if (!r_rd_ack && r_rd_data[5] && r_rd_data[2]) begin
                    w_state_nx = S_STAT_RD;
                end else begin
                    w_link_nx  = r_link_up & ~w_sel;
                    w_speed_nx = r_speed & ~w_smask;
                    w_dup_nx   = r_full_duplex & ~w_sel;
                    w_ch_nx    = w_last ? r_ch : r_ch + 2'd1;
                    w_state_nx = w_last ? S_IDLE : S_BMSR_RD;
                end
            end
            S_STAT_RD: begin
                w_issue    = 1'b1;
                w_reg      = STAT_REG;
                w_state_nx = S_STAT_W;
            end
            S_STAT_W: w_state_nx = op_done ? S_STAT_CHK : S_STAT_W;
            S_STAT_CHK: begin
                if (r_rd_ack) begin
                    w_link_nx  = r_link_up & ~w_sel;
                    w_speed_nx = r_speed & ~w_smask;
                end else begin
                    w_link_nx  = (r_link_up & ~w_sel) | (w_sel & {NUM_PHY{w_lnk}});
                    w_speed_nx = (r_speed & ~w_smask) | (w_smask & {NUM_PHY{w_spd}});
                    w_dup_nx   = (r_full_duplex & ~w_sel) | (w_sel & {NUM_PHY{r_rd_data[13]}});
                end
                w_ch_nx    = w_last ? r_ch : r_ch + 2'd1;
                w_state_nx = w_last ? S_IDLE : S_BMSR_RD;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // request flags, poll timer and trigger synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync      <= 3'b000;
            r_rst_pend  <= 1'b0;
            r_poll_pend <= 1'b0;
            r_tmr       <= 24'd0;
        end else begin
            r_sync      <= {r_sync[1:0], soft_rst_trig};
            r_rst_pend  <= w_rst_clr ? 1'b0 : (r_rst_pend | w_trig_edge);
            r_poll_pend <= w_poll_clr ? 1'b0 : (r_poll_pend | w_tick);
            r_tmr       <= w_tick ? 24'd0 : r_tmr + 24'd1;
        end
    end

    // FSM state, captured read response and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ch          <= 2'd0;
            r_polls       <= 8'd0;
            r_rd_data     <= 16'h0000;
            r_rd_ack      <= 1'b0;
            r_op_exec     <= 1'b0;
            r_op_rh_wl    <= 1'b1;
            r_op_phy_addr <= 5'd0;
            r_op_addr     <= 5'd0;
            r_op_wr_data  <= 16'h0000;
            r_link_up     <= '0;
            r_speed       <= '0;
            r_full_duplex <= '0;
            r_rst_fail    <= '0;
            r_busy        <= 1'b0;
            r_led         <= 2'b00;
        end else begin
            r_state       <= w_state_nx;
            r_ch          <= w_ch_nx;
            r_polls       <= w_polls_nx;
            if (op_done && w_rd_wait) begin
                r_rd_data <= op_rd_data;
                r_rd_ack  <= op_rd_ack;
            end
            r_op_exec     <= w_issue;
            if (w_issue) begin
                r_op_rh_wl    <= w_rd;
                r_op_phy_addr <= PHY_ADDR_BASE + {3'b000, r_ch};
                r_op_addr     <= w_reg;
                r_op_wr_data  <= w_wdata;
            end
            r_link_up     <= w_link_nx;
            r_speed       <= w_speed_nx;
            r_full_duplex <= w_dup_nx;
            r_rst_fail    <= w_fail_nx;
            r_busy        <= (w_state_nx != S_IDLE);
            r_led         <= w_link_nx[0] ? w_speed_nx[1:0] : 2'b00;
        end
    end

`ifdef MDIO_ERR_CNT_EN
    logic [8*NUM_PHY-1:0] r_err_cnt;

    // saturating per-PHY count of NACKed reads; only rst_n clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (op_done && w_rd_wait && op_rd_ack) begin
            for (int n = 0; n < NUM_PHY; n++) begin
                if (w_sel[n] && (r_err_cnt[8*n +: 8] != 8'hFF)) begin
                    r_err_cnt[8*n +: 8] <= r_err_cnt[8*n +: 8] + 8'd1;
                end
            end
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = '0;
`endif

    assign op_exec     = r_op_exec;
    assign op_rh_wl    = r_op_rh_wl;
    assign op_phy_addr = r_op_phy_addr;
    assign op_addr     = r_op_addr;
    assign op_wr_data  = r_op_wr_data;
    assign link_up     = r_link_up;
    assign speed       = r_speed;
    assign full_duplex = r_full_duplex;
    assign rst_fail    = r_rst_fail;
    assign busy        = r_busy;
    assign led         = r_led;

endmodule

// File: tb/tb_mdio_phy_mgr.sv
// Scoreboard bench for mdio_phy_mgr: a behavioural MDIO controller/PHY model answers ops,
// expected ops are queued by the stimulus and checked by a separate monitor.
module tb_mdio_phy_mgr;

    typedef struct {
        logic        rd;
        logic [4:0]  pa;
        logic [4:0]  ra;
        logic [15:0] wd;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        soft_rst_trig = 1'b0;
    logic        op_done = 1'b0;
    logic        op_rd_ack = 1'b0;
    logic [15:0] op_rd_data = 16'h0000;
    logic        op_exec, op_rh_wl, busy;
    logic [4:0]  op_phy_addr, op_addr;
    logic [15:0] op_wr_data, err_cnt;
    logic [1:0]  link_up, full_duplex, rst_fail, led;
    logic [3:0]  speed;

    int   n_checks = 0;
    int   n_pass = 0;
    int   ops_seen = 0;
    int   latency = 2;
    bit   sb_en = 1'b1;
    bit   nack0 = 1'b0;
    logic [15:0] bmsr [2];
    logic [15:0] stat [2];
    int   bmcr_busy [2];
    int   bmcr_cnt [2];
    op_t  exp_q [$];
    op_t  mon_e;

    mdio_phy_mgr #(.NUM_PHY(2), .POLL_PERIOD(24'd300)) dut (
        .clk(clk), .rst_n(rst_n), .soft_rst_trig(soft_rst_trig),
        .op_done(op_done), .op_rd_ack(op_rd_ack), .op_rd_data(op_rd_data),
        .op_exec(op_exec), .op_rh_wl(op_rh_wl), .op_phy_addr(op_phy_addr),
        .op_addr(op_addr), .op_wr_data(op_wr_data), .link_up(link_up),
        .speed(speed), .full_duplex(full_duplex), .rst_fail(rst_fail),
        .busy(busy), .led(led), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask

    task automatic push(input logic rd, input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd);
        op_t e;
        e.rd = rd; e.pa = pa; e.ra = ra; e.wd = wd;
        exp_q.push_back(e);
    endtask

    task automatic wait_busy(input logic v, input int lim, input string nm);
        int k = 0;
        while (busy !== v && k < lim) begin @(negedge clk); k++; end
        chk(nm, 32'(busy), 32'(v));
    endtask

    task automatic pulse_soft_rst();
        soft_rst_trig = 1'b1;
        repeat (4) @(negedge clk);
        soft_rst_trig = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_op_exec"}, 32'(op_exec), 32'd0);
        chk({tag, "_op_rh_wl"}, 32'(op_rh_wl), 32'd1);
        chk({tag, "_op_phy_addr"}, 32'(op_phy_addr), 32'd0);
        chk({tag, "_op_addr"}, 32'(op_addr), 32'd0);
        chk({tag, "_op_wr_data"}, 32'(op_wr_data), 32'd0);
        chk({tag, "_link_up"}, 32'(link_up), 32'd0);
        chk({tag, "_speed"}, 32'(speed), 32'd0);
        chk({tag, "_full_duplex"}, 32'(full_duplex), 32'd0);
        chk({tag, "_rst_fail"}, 32'(rst_fail), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_led"}, 32'(led), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    // controller + PHY model: answers each op after 'latency' cycles
    initial begin : ctrl_model
        logic [4:0] pa, ra;
        logic       rd;
        int         p, lat;
        forever begin
            @(negedge clk);
            if (op_exec) begin
                pa = op_phy_addr; ra = op_addr; rd = op_rh_wl; lat = latency;
                p = (pa == 5'd2) ? 1 : 0;
                repeat (lat) @(negedge clk);
                op_rd_ack = nack0 && (p == 0) && rd;
                if (!rd) begin
                    if (ra == 5'd0) bmcr_cnt[p] = 0;
                    op_rd_data = 16'h0000;
                end else if (ra == 5'd0) begin
                    bmcr_cnt[p]++;
                    op_rd_data = (bmcr_cnt[p] <= bmcr_busy[p]) ? 16'h8000 : 16'h0000;
                end else if (ra == 5'd1) op_rd_data = bmsr[p];
                else if (ra == 5'd17) op_rd_data = stat[p];
                else op_rd_data = 16'hFFFF;
                op_done = 1'b1;
                @(negedge clk);
                op_done = 1'b0;
            end
        end
    end

    // monitor: every op_exec pulse is popped against the expected queue
    always @(negedge clk) begin
        if (op_exec) begin
            ops_seen++;
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_op: got phy %0d reg %0d rd %0b, expected no operation",
                             op_phy_addr, op_addr, op_rh_wl);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("op_rh_wl", 32'(op_rh_wl), 32'(mon_e.rd));
                    chk("op_phy_addr", 32'(op_phy_addr), 32'(mon_e.pa));
                    chk("op_addr", 32'(op_addr), 32'(mon_e.ra));
                    if (!mon_e.rd) chk("op_wr_data", 32'(op_wr_data), 32'(mon_e.wd));
                end
            end
        end
    end

    initial begin
        int base, k;
        bmsr[0] = 16'h0024; bmsr[1] = 16'h0024;
        stat[0] = 16'hA000; stat[1] = 16'hA000;
        bmcr_busy[0] = 0; bmcr_busy[1] = 0;
        bmcr_cnt[0] = 0; bmcr_cnt[1] = 0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        // both PHYs up, 1000M full duplex
        push(1'b1, 5'd1, 5'd1, 16'h0); push(1'b1, 5'd1, 5'd17, 16'h0);
        push(1'b1, 5'd2, 5'd1, 16'h0); push(1'b1, 5'd2, 5'd17, 16'h0);
        wait_busy(1'b1, 700, "sweep1_start");
        wait_busy(1'b0, 300, "sweep1_end");
        chk("sweep1_link_up", 32'(link_up), 32'h3);
        chk("sweep1_speed", 32'(speed), 32'hF);
        chk("sweep1_duplex", 32'(full_duplex), 32'h3);
        chk("sweep1_led", 32'(led), 32'h3);
        chk("sweep1_queue", 32'(exp_q.size()), 32'd0);

        // PHY 0 link down: no STAT_REG read for it
        bmsr[0] = 16'h0020;
        push(1'b1, 5'd1, 5'd1, 16'h0); push(1'b1, 5'd2, 5'd1, 16'h0); push(1'b1, 5'd2, 5'd17, 16'h0);
        wait_busy(1'b1, 700, "sweep2_start");
        wait_busy(1'b0, 300, "sweep2_end");
        chk("sweep2_link_up", 32'(link_up), 32'h2);
        chk("sweep2_speed", 32'(speed), 32'hC);
        chk("sweep2_duplex", 32'(full_duplex), 32'h2);
        chk("sweep2_led", 32'(led), 32'h0);
        chk("sweep2_queue", 32'(exp_q.size()), 32'd0);

        // soft reset, bit15 clears on the third read of each PHY
        bmcr_busy[0] = 2; bmcr_busy[1] = 2;
        for (int p = 1; p <= 2; p++) begin
            push(1'b0, 5'(p), 5'd0, 16'hA140);
            for (int r = 0; r < 3; r++) push(1'b1, 5'(p), 5'd0, 16'h0);
        end
        pulse_soft_rst();
        wait_busy(1'b1, 50, "rst1_start");
        wait_busy(1'b0, 400, "rst1_end");
        chk("rst1_rst_fail", 32'(rst_fail), 32'h0);
        chk("rst1_queue", 32'(exp_q.size()), 32'd0);

        // realign on a tick, then PHY 1 never clears bit15
        push(1'b1, 5'd1, 5'd1, 16'h0); push(1'b1, 5'd2, 5'd1, 16'h0); push(1'b1, 5'd2, 5'd17, 16'h0);
        wait_busy(1'b1, 700, "sweep3_start");
        wait_busy(1'b0, 300, "sweep3_end");
        bmcr_busy[0] = 0; bmcr_busy[1] = 255;
        push(1'b0, 5'd1, 5'd0, 16'hA140); push(1'b1, 5'd1, 5'd0, 16'h0);
        push(1'b0, 5'd2, 5'd0, 16'hA140);
        for (int r = 0; r < 16; r++) push(1'b1, 5'd2, 5'd0, 16'h0);
        pulse_soft_rst();
        wait_busy(1'b1, 50, "rst2_start");
        wait_busy(1'b0, 600, "rst2_end");
        chk("rst2_rst_fail", 32'(rst_fail), 32'h2);
        chk("rst2_queue", 32'(exp_q.size()), 32'd0);

        // slow sweep spanning a tick and a soft-reset edge
        bmcr_busy[1] = 0;
        latency = 120;
        push(1'b1, 5'd1, 5'd1, 16'h0); push(1'b1, 5'd2, 5'd1, 16'h0); push(1'b1, 5'd2, 5'd17, 16'h0);
        wait_busy(1'b1, 700, "sweep4_start");
        base = ops_seen;
        repeat (20) @(negedge clk);
        pulse_soft_rst();
        push(1'b0, 5'd1, 5'd0, 16'hA140); push(1'b1, 5'd1, 5'd0, 16'h0);
        push(1'b0, 5'd2, 5'd0, 16'hA140); push(1'b1, 5'd2, 5'd0, 16'h0);
        push(1'b1, 5'd1, 5'd1, 16'h0); push(1'b1, 5'd2, 5'd1, 16'h0); push(1'b1, 5'd2, 5'd17, 16'h0);
        k = 0;
        while (ops_seen < base + 3 && k < 1000) begin @(negedge clk); k++; end
        chk("sweep4_ops", 32'(ops_seen >= base + 3), 32'd1);
        repeat (5) @(negedge clk);
        latency = 2;
        k = 0;
        while (exp_q.size() != 0 && k < 1000) begin @(negedge clk); k++; end
        wait_busy(1'b0, 100, "sweep4_end");
        repeat (100) @(negedge clk);
        chk("sweep4_queue", 32'(exp_q.size()), 32'd0);
        chk("sweep4_idle", 32'(busy), 32'd0);
        chk("sweep4_rst_fail", 32'(rst_fail), 32'h0);
        chk("sweep4_link_up", 32'(link_up), 32'h2);
        sb_en = 1'b0;

`ifdef MDIO_ERR_CNT_EN
        // NACK every PHY 0 read until its counter saturates
        nack0 = 1'b1;
        for (int i = 0; i < 40 && err_cnt[7:0] != 8'hFF; i++) begin
            pulse_soft_rst();
            wait_busy(1'b1, 700, "nack_start");
            wait_busy(1'b0, 700, "nack_end");
        end
        nack0 = 1'b0;
        chk("err_cnt_phy0", 32'(err_cnt[7:0]), 32'd255);
        chk("err_cnt_phy1", 32'(err_cnt[15:8]), 32'd0);
`endif

        // rst_n asserted mid-operation
        pulse_soft_rst();
        wait_busy(1'b1, 700, "midop_start");
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset("midop");
        @(posedge clk);
        #1;
        check_reset("midop_held");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mdio_phy_mgr.md
Name: mdio_phy_mgr

Overview:
Parametrised MDIO management sequencer for 1..NUM_PHY Ethernet PHYs on one shared MDIO bus. Drives the existing MDIO controller op interface. Services a soft-reset request by writing BMCR on every PHY and confirming the reset bit self-clears. Periodically sweeps all PHYs for link, speed and duplex, and exports per-PHY status plus a PHY-0 speed LED.

Parameters:
NUM_PHY, 2, number of PHYs managed (1..4)
PHY_ADDR_BASE, 5'd1, MDIO address of PHY 0; PHY n uses PHY_ADDR_BASE+n (5-bit wrap)
POLL_PERIOD, 24'd100_000, clk cycles between sweep ticks
RST_WORD, 16'hA140, value written to BMCR (reg 0) on soft reset
STAT_REG, 5'd17, PHY-specific status register address
RST_MAX_POLLS, 8'd16, BMCR reads allowed for bit15 to clear before failure

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
soft_rst_trig  in  1  asynchronous soft-reset request; rising edge acts
op_done  in  1  controller: operation finished (one-cycle pulse)
op_rd_ack  in  1  controller: 0 = PHY acknowledged read, 1 = NACK
op_rd_data  in  16  controller: read data, valid with op_done
op_exec  out  1  one-cycle start pulse to controller
op_rh_wl  out  1  1 = read, 0 = write
op_phy_addr  out  5  PHY address of operation
op_addr  out  5  register address
op_wr_data  out  16  write data
link_up  out  NUM_PHY  per-PHY link valid
speed  out  2*NUM_PHY  per-PHY speed, [2n+1:2n]: 00 unknown, 01 10M, 10 100M, 11 1000M
full_duplex  out  NUM_PHY  per-PHY duplex
rst_fail  out  NUM_PHY  sticky: PHY reset did not self-clear
busy  out  1  sequencer not in IDLE
led  out  2  link_up[0] ? speed[1:0] : 00
err_cnt  out  8*NUM_PHY  NACK counters (see Optional Feature)

Behaviour:
- Reset: all outputs 0, except op_rh_wl=1. ch=0. Flags clear. FSM=IDLE.
- soft_rst_trig: 3-FF synchroniser, rising-edge detect. Sets rst_pend. A repeat edge while rst_pend is set is absorbed.
- Timer: counts 0..POLL_PERIOD-1; at terminal count sets poll_pend and wraps. Extra ticks while poll_pend is set are absorbed (one-deep).
- Op issue: op_exec high exactly one cycle. op_rh_wl, op_phy_addr, op_addr and op_wr_data are set in the same cycle and held until the next issue. FSM waits for op_done; no timeout. op_done outside a WAIT state is ignored.
- IDLE priority: rst_pend over poll_pend. Starting a reset clears rst_pend and clears rst_fail for all PHYs. Starting a sweep clears poll_pend. Both start with ch=0.
- Reset sweep, per ch:
  - RST_WR: write RST_WORD to reg 0.
  - RST_RD: read reg 0; poll counter increments per read.
  - RST_CHK: ack=0 and bit15=0 -> next ch. Otherwise, if polls < RST_MAX_POLLS -> RST_RD; else set rst_fail[ch] and go to next ch.
  - After the last ch -> IDLE.
- Status sweep, per ch:
  - BMSR_RD: read reg 1.
  - BMSR_CHK: ack=0, bit5=1 (AN complete) and bit2=1 (link) -> STAT_RD. Otherwise link_up[ch]=0, speed=00, full_duplex=0, next ch.
  - STAT_RD: read STAT_REG.
  - STAT_CHK: ack=1 -> link_up[ch]=0, speed=00. Otherwise link_up[ch]=1; speed from bits[15:14] (00->01, 01->10, 10->11, 11->00 with link_up=0); full_duplex=bit13.
  - After the last ch -> IDLE.
- rst_pend arriving mid-sweep: the current sweep completes; reset starts on return to IDLE.
- rst_n low mid-operation: immediate return to reset state. The controller is not notified.

Optional Feature:
Macro MDIO_ERR_CNT_EN.
- Defined: err_cnt[8n+7:8n] increments on every op_done with op_rd_ack=1 for a read issued to PHY n. Saturates at 255. Cleared only by rst_n.
- Undefined: err_cnt tied to 0; no counter registers synthesised.

Test Plan:
1. NUM_PHY=2, PHY model returns BMSR 16'h0024 and reg17 16'h A000 -> after one sweep: link_up=2'b11, speed=4'b1111, full_duplex=2'b11, led=2'b11; 4 op_exec pulses with op_phy_addr 1,1,2,2.
2. Pulse soft_rst_trig; BMCR reads return 16'h8000 twice, then 16'h0000 -> write 16'hA140 to reg 0 per PHY, 3 reads each, rst_fail=00, busy falls afterwards.
3. PHY 1 BMCR always returns 16'h8000 -> exactly 16 reads of PHY 1, rst_fail=2'b10, FSM returns to IDLE.
4. PHY 0 BMSR 16'h0020 (link down) -> link_up[0]=0, speed[1:0]=00, led=00, no reg17 read for PHY 0.
5. soft_rst_trig edge and timer tick both during a status sweep -> sweep completes, reset sweep runs next, then exactly one status sweep.
6. MDIO_ERR_CNT_EN defined, op_rd_ack forced 1 for 300 reads to PHY 0 -> err_cnt[7:0]=255, err_cnt[15:8]=0; rst_n low mid-op -> all outputs at reset values next cycle.
